// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and period of an asynchronous PWM line and
// reconstructs the 4-bit duty code with a rounded, saturating 5-step divide.
`timescale 1ns/1ps
module pwm_decoder #(
  parameter int CNT_W   = 16,
  parameter int MIN_PER = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             Pulse,
  output logic [3:0]       Duty,
  output logic [CNT_W-1:0] High,
  output logic [CNT_W-1:0] Period,
  output logic             Valid,
  output logic             Timeout,
  output logic             Short
);

  typedef enum logic [1:0] {S_WAIT, S_MEAS, S_TOUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_sync1, r_sync2, r_sync3;
  logic             w_rise;
  state_t           r_state, w_next;
  logic             w_restart, w_snap, w_tout_enter, w_short, w_div_start;
  logic [CNT_W-1:0] r_per_cnt, r_high_cnt;

  logic             r_busy;
  logic [2:0]       r_div_cnt;
  logic [CNT_W-1:0] r_rem, r_d_per, r_d_high;
  logic [4:0]       r_num_lo;
  logic [3:0]       r_q;
  logic [CNT_W+4:0] w_num;
  logic [CNT_W:0]   w_trial;
  logic             w_ge;
  logic [CNT_W-1:0] w_rem_next;
  logic [4:0]       w_q_next;

  // r_sync3 is the previous synchronized sample, used only for edge detection.
  always_ff @(posedge sysclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= Pulse;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_next;
  end

  // A rising edge always wins over a timeout reached in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_next       = r_state;
    w_restart    = 1'b0;
    w_snap       = 1'b0;
    w_tout_enter = 1'b0;
    case (r_state)
      S_WAIT, S_MEAS: begin
        if (w_rise) begin
          w_restart = 1'b1;
          w_snap    = (r_state == S_MEAS);
          w_next    = S_MEAS;
        end else if (r_per_cnt == CNT_MAX) begin
          w_tout_enter = 1'b1;
          w_next       = S_TOUT;
        end
      end
      S_TOUT: begin
        if (w_rise) begin
          w_restart = 1'b1;
          w_next    = S_MEAS;
        end
      end
      default: w_next = S_WAIT;
    endcase
  end

  assign w_short     = w_snap && (r_per_cnt < CNT_W'(MIN_PER));
  assign w_div_start = w_snap && !w_short;

  // Restart loads 1: the edge cycle itself is the first cycle of the new period.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
    end else if (w_restart) begin
      r_per_cnt  <= CNT_W'(1);
      r_high_cnt <= CNT_W'(1);
    end else if (r_state != S_TOUT) begin
      if (r_per_cnt != CNT_MAX)
        r_per_cnt <= r_per_cnt + CNT_W'(1);
      if (r_sync2 && (r_high_cnt != CNT_MAX))
        r_high_cnt <= r_high_cnt + CNT_W'(1);
    end
  end

  // Numerator 16*High + Period/2; its top CNT_W bits are already below Period.
  assign w_num      = {1'b0, r_high_cnt, 4'b0000} + {6'b000000, r_per_cnt[CNT_W-1:1]};
  assign w_trial    = {r_rem, r_num_lo[4]};
  assign w_ge       = (w_trial >= {1'b0, r_d_per});
  assign w_rem_next = w_ge ? CNT_W'(w_trial - {1'b0, r_d_per}) : w_trial[CNT_W-1:0];
  assign w_q_next   = {r_q, w_ge};

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_div_cnt <= '0;
      r_rem     <= '0;
      r_num_lo  <= '0;
      r_q       <= '0;
      r_d_per   <= '0;
      r_d_high  <= '0;
      Duty      <= '0;
      High      <= '0;
      Period    <= '0;
      Valid     <= 1'b0;
      Timeout   <= 1'b0;
      Short     <= 1'b0;
    end else begin
      Valid <= 1'b0;
      Short <= w_short;
      if (w_div_start) begin
        r_busy    <= 1'b1;
        r_div_cnt <= '0;
        r_rem     <= w_num[CNT_W+4:5];
        r_num_lo  <= w_num[4:0];
        r_q       <= '0;
        r_d_per   <= r_per_cnt;
        r_d_high  <= r_high_cnt;
      end else if (r_busy) begin
        r_rem     <= w_rem_next;
        r_num_lo  <= {r_num_lo[3:0], 1'b0};
        r_q       <= w_q_next[3:0];
        r_div_cnt <= r_div_cnt + 3'd1;
        if (r_div_cnt == 3'd4) begin
          r_busy <= 1'b0;
          Valid  <= 1'b1;
          Duty   <= w_q_next[4] ? 4'hF : w_q_next[3:0];
          High   <= r_d_high;
          Period <= r_d_per;
        end
      end
      if (w_tout_enter) begin
        Timeout <= 1'b1;
        Duty    <= {4{r_sync2}};
        High    <= '0;
        Period  <= '0;
        Valid   <= 1'b1;
      end else if (w_restart) begin
        Timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: each closing rising edge pushes the expected
// result; every Valid pops and compares it.
`timescale 1ns/1ps
module tb_pwm_decoder;
  localparam int CNT_W   = 16;
  localparam int MIN_PER = 8;

  logic             sysclk = 1'b0;
  logic             reset  = 1'b1;
  logic             Pulse  = 1'b0;
  logic [3:0]       Duty;
  logic [CNT_W-1:0] High, Period;
  logic             Valid, Timeout, Short;

  pwm_decoder #(.CNT_W(CNT_W), .MIN_PER(MIN_PER)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .Pulse  (Pulse),
    .Duty   (Duty),
    .High   (High),
    .Period (Period),
    .Valid  (Valid),
    .Timeout(Timeout),
    .Short  (Short)
  );

  always #10 sysclk = ~sysclk;

  typedef struct {
    int duty;
    int high;
    int period;
    int tout;
    int t_push;
    int lat_chk;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, cyc = 0;
  int   exp_short = 0, short_seen = 0;
  int   have_prev = 0, prev_per = 0, prev_hi = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_duty(input int h, input int p);
    int d;
    d = (16 * h + p / 2) / p;
    return (d > 15) ? 15 : d;
  endfunction

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin : mon
    exp_t e;
    if (Short) short_seen++;
    if (Valid) begin
      if (sb.size() == 0) begin
        check("valid_unexp", int'(Valid), 0);
      end else begin
        e = sb.pop_front();
        check("duty",    int'(Duty),    e.duty);
        check("high",    int'(High),    e.high);
        check("period",  int'(Period),  e.period);
        check("timeout", int'(Timeout), e.tout);
        if (e.lat_chk != 0)
          check("latency_le9", (cyc - e.t_push <= 9) ? 1 : 0, 1);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_duty",    int'(Duty),    0);
    check("rst_high",    int'(High),    0);
    check("rst_period",  int'(Period),  0);
    check("rst_valid",   int'(Valid),   0);
    check("rst_timeout", int'(Timeout), 0);
    check("rst_short",   int'(Short),   0);
  endtask

  // One PWM period starting with a rising edge; rst_at >= 0 pulses reset that cycle.
  task automatic drive_period(input int per, input int hi, input int rst_at);
    for (int c = 0; c < per; c++) begin
      Pulse = (c < hi);
      if (c == 0) begin
        if (have_prev != 0) begin
          if (prev_per < MIN_PER) exp_short++;
          else sb.push_back('{exp_duty(prev_hi, prev_per), prev_hi, prev_per, 0, cyc, 1});
        end
        have_prev = 1;
        prev_per  = per;
        prev_hi   = hi;
      end
      if (c == rst_at) begin
        reset = 1'b1;
        sb.delete();
        have_prev = 0;
      end else if (reset) begin
        check_reset_outputs();
        reset = 1'b0;
      end
      @(negedge sysclk);
    end
  endtask

  task automatic hold_low(input int n);
    Pulse = 1'b0;
    sb.push_back('{0, 0, 0, 1, cyc, 0});
    have_prev = 0;
    repeat (n) @(negedge sysclk);
    check("tout_level", int'(Timeout), 1);
  endtask

  initial begin : watchdog
    #(80000 * 20);
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int dseq[4];
    dseq = '{1, 8, 12, 14};

    repeat (3) @(negedge sysclk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge sysclk);

    repeat (4) drive_period(16, 8, -1);
    repeat (3) drive_period(16, 15, -1);
    repeat (3) drive_period(16, 1, -1);
    repeat (3) drive_period(160, 150, -1);

    repeat (4) drive_period(5, 2, -1);
    check("duty_hold",  int'(Duty), exp_duty(150, 160));
    check("shorts_mid", short_seen, exp_short);

    foreach (dseq[i]) repeat (3) drive_period(16, dseq[i], -1);

    drive_period(16, 8, -1);
    drive_period(16, 2, 3);
    repeat (3) drive_period(16, 8, -1);

    hold_low(70000);
    drive_period(16, 4, -1);
    check("tout_clear", int'(Timeout), 0);
    repeat (4) drive_period(16, 4, -1);

    repeat (12) @(negedge sysclk);
    check("sb_empty", sb.size(), 0);
    check("shorts",   short_seen, exp_short);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
